// File: rtl/scanner_pkg.sv
// Shared arbiter helpers: state encodings and index-width function.
// Used by priority_scanner and sibling arbiters.
package scanner_pkg;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  function automatic int idx_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder, selectable MSB- or LSB-first.
// Reused standalone and inside priority_scanner.
module priority_encoder
  import scanner_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IDX_W     = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [IDX_W-1:0] out,
  output logic             any
);

  // Later matches overwrite earlier ones, so loop direction sets priority.
  always_comb begin
    out = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (in[i]) out = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (in[i]) out = IDX_W'(i);
    end
  end

  assign any = |in;

endmodule

// File: rtl/priority_scanner.sv
// Accepts a request vector and emits each set index, one per
// handshake, in priority order with ordinal and last flag.
module priority_scanner
  import scanner_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IDX_W     = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   out_seq,
  output logic             zero_vec
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [IDX_W:0]   seq_q, seq_d;
  logic             zero_q, zero_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             single;

  priority_encoder #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .IDX_W    (IDX_W)
  ) u_enc (
    .in (rem_q),
    .out(enc_idx),
    .any(enc_any)
  );

  assign single    = (rem_q & (rem_q - ONE)) == '0;
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_SCAN) && enc_any;
  assign out_idx   = enc_idx;
  assign out_last  = out_valid && single;
  assign out_seq   = seq_q;
  assign zero_vec  = zero_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    seq_d   = seq_q;
    zero_d  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (in_valid) begin
          if (in_vec != '0) begin
            rem_d   = in_vec;
            seq_d   = '0;
            state_d = S_SCAN;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      (state_q == S_SCAN): begin
        if (out_ready) begin
          rem_d = rem_q & ~(ONE << enc_idx);
          seq_d = seq_q + 1'b1;
          if (out_last) begin
            seq_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      seq_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_priority_scanner.sv
// Directed bench for priority_scanner: MSB/LSB order, walking one,
// zero vector, backpressure, back-to-back and mid-scan reset.
module tb_priority_scanner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // MSB-first, 256 wide
  logic         m_iv, m_ir, m_ov, m_or, m_ol, m_zv;
  logic [255:0] m_vec;
  logic [7:0]   m_idx;
  logic [8:0]   m_seq;

  // LSB-first, 256 wide
  logic         l_iv, l_ir, l_ov, l_or, l_ol, l_zv;
  logic [255:0] l_vec;
  logic [7:0]   l_idx;
  logic [8:0]   l_seq;

  // MSB-first, 8 wide
  logic       s_iv, s_ir, s_ov, s_or, s_ol, s_zv;
  logic [7:0] s_vec;
  logic [2:0] s_idx;
  logic [3:0] s_seq;

  priority_scanner #(.WIDTH(256), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir),
    .in_vec(m_vec), .out_valid(m_ov), .out_ready(m_or),
    .out_idx(m_idx), .out_last(m_ol), .out_seq(m_seq),
    .zero_vec(m_zv));

  priority_scanner #(.WIDTH(256), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .in_valid(l_iv), .in_ready(l_ir),
    .in_vec(l_vec), .out_valid(l_ov), .out_ready(l_or),
    .out_idx(l_idx), .out_last(l_ol), .out_seq(l_seq),
    .zero_vec(l_zv));

  priority_scanner #(.WIDTH(8), .MSB_FIRST(1'b1)) u_s (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir),
    .in_vec(s_vec), .out_valid(s_ov), .out_ready(s_or),
    .out_idx(s_idx), .out_last(s_ol), .out_seq(s_seq),
    .zero_vec(s_zv));

  task automatic test_reset();
    rst = 1'b1;
    m_iv = 0; m_or = 1; m_vec = '0;
    l_iv = 0; l_or = 1; l_vec = '0;
    s_iv = 0; s_or = 1; s_vec = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if ({m_ov, m_ir, m_ol, m_zv, m_idx, m_seq} !== {4'b0100, 8'd0, 9'd0})
      $display("FAIL reset_m: got ov=%b ir=%b last=%b zv=%b idx=%0d seq=%0d want 0 1 0 0 0 0",
               m_ov, m_ir, m_ol, m_zv, m_idx, m_seq);
    else n_pass++;
    n_total++;
    if ({l_ov, l_ir, l_ol, l_zv, l_idx, l_seq} !== {4'b0100, 8'd0, 9'd0})
      $display("FAIL reset_l: got ov=%b ir=%b last=%b zv=%b idx=%0d seq=%0d want 0 1 0 0 0 0",
               l_ov, l_ir, l_ol, l_zv, l_idx, l_seq);
    else n_pass++;
    n_total++;
    if ({s_ov, s_ir, s_ol, s_zv, s_idx, s_seq} !== {4'b0100, 3'd0, 4'd0})
      $display("FAIL reset_s: got ov=%b ir=%b last=%b zv=%b idx=%0d seq=%0d want 0 1 0 0 0 0",
               s_ov, s_ir, s_ol, s_zv, s_idx, s_seq);
    else n_pass++;
  endtask

  task automatic test_msb_order();
    int exp_idx [3] = '{255, 17, 0};
    m_vec = '0;
    m_vec[255] = 1'b1; m_vec[17] = 1'b1; m_vec[0] = 1'b1;
    m_iv = 1'b1; m_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_iv = 1'b0;
      n_total++;
      if (!(m_ov === 1'b1 && m_ir === 1'b0 && m_idx === 8'(exp_idx[k]) &&
            m_seq === 9'(k) && m_ol === (k == 2)))
        $display("FAIL msb_emit%0d: got ov=%b ir=%b idx=%0d seq=%0d last=%b want 1 0 %0d %0d %b",
                 k, m_ov, m_ir, m_idx, m_seq, m_ol, exp_idx[k], k, k == 2);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (!(m_ir === 1'b1 && m_ov === 1'b0))
      $display("FAIL msb_done: got ir=%b ov=%b want 1 0", m_ir, m_ov);
    else n_pass++;
  endtask

  task automatic test_lsb_order();
    int exp_idx [3] = '{0, 17, 255};
    l_vec = '0;
    l_vec[255] = 1'b1; l_vec[17] = 1'b1; l_vec[0] = 1'b1;
    l_iv = 1'b1; l_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      l_iv = 1'b0;
      n_total++;
      if (!(l_ov === 1'b1 && l_idx === 8'(exp_idx[k]) &&
            l_seq === 9'(k) && l_ol === (k == 2)))
        $display("FAIL lsb_emit%0d: got ov=%b idx=%0d seq=%0d last=%b want 1 %0d %0d %b",
                 k, l_ov, l_idx, l_seq, l_ol, exp_idx[k], k, k == 2);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (!(l_ir === 1'b1 && l_ov === 1'b0))
      $display("FAIL lsb_done: got ir=%b ov=%b want 1 0", l_ir, l_ov);
    else n_pass++;
  endtask

  task automatic test_walking_one();
    int bad = 0;
    m_or = 1'b1;
    for (int i = 255; i >= 0; i--) begin
      m_vec = '0;
      m_vec[i] = 1'b1;
      m_iv = 1'b1;
      @(negedge clk);
      m_iv = 1'b0;
      n_total++;
      if (!(m_ov === 1'b1 && m_idx === 8'(i) && m_ol === 1'b1 && m_seq === 9'd0)) begin
        if (bad < 4)
          $display("FAIL walk%0d: got ov=%b idx=%0d last=%b seq=%0d want 1 %0d 1 0",
                   i, m_ov, m_idx, m_ol, m_seq, i);
        bad++;
      end else n_pass++;
      @(negedge clk);
      n_total++;
      if (!(m_ov === 1'b0 && m_ir === 1'b1)) begin
        if (bad < 4)
          $display("FAIL walk_idle%0d: got ov=%b ir=%b want 0 1", i, m_ov, m_ir);
        bad++;
      end else n_pass++;
    end
  endtask

  task automatic test_zero_vec();
    m_vec = '0;
    m_iv = 1'b1;
    @(negedge clk);
    m_iv = 1'b0;
    n_total++;
    if (!(m_zv === 1'b1 && m_ov === 1'b0 && m_ir === 1'b1))
      $display("FAIL zero_pulse: got zv=%b ov=%b ir=%b want 1 0 1", m_zv, m_ov, m_ir);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (!(m_zv === 1'b0 && m_ov === 1'b0 && m_ir === 1'b1))
      $display("FAIL zero_after: got zv=%b ov=%b ir=%b want 0 0 1", m_zv, m_ov, m_ir);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int exp_idx [4] = '{7, 6, 5, 4};
    s_vec = 8'hF0;
    s_iv = 1'b1;
    s_or = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      s_iv = 1'b0;
      s_vec = 8'h0F;
      n_total++;
      if (!(s_ov === 1'b1 && s_idx === 3'd7 && s_seq === 4'd0 && s_ol === 1'b0))
        $display("FAIL bp_hold%0d: got ov=%b idx=%0d seq=%0d last=%b want 1 7 0 0",
                 c, s_ov, s_idx, s_seq, s_ol);
      else n_pass++;
    end
    s_or = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      n_total++;
      if (!(s_ov === 1'b1 && s_idx === 3'(exp_idx[k]) &&
            s_seq === 4'(k) && s_ol === (k == 3)))
        $display("FAIL bp_emit%0d: got ov=%b idx=%0d seq=%0d last=%b want 1 %0d %0d %b",
                 k, s_ov, s_idx, s_seq, s_ol, exp_idx[k], k, k == 3);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (!(s_ov === 1'b0 && s_ir === 1'b1))
      $display("FAIL bp_done: got ov=%b ir=%b want 0 1", s_ov, s_ir);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    m_or = 1'b1;
    m_vec = '0;
    m_vec[5] = 1'b1; m_vec[2] = 1'b1;
    m_iv = 1'b1;
    @(negedge clk);
    m_vec = '0;
    m_vec[9] = 1'b1;
    n_total++;
    if (!(m_ov === 1'b1 && m_ir === 1'b0 && m_idx === 8'd5 && m_ol === 1'b0))
      $display("FAIL b2b_a0: got ov=%b ir=%b idx=%0d last=%b want 1 0 5 0",
               m_ov, m_ir, m_idx, m_ol);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (!(m_ov === 1'b1 && m_idx === 8'd2 && m_ol === 1'b1 && m_seq === 9'd1))
      $display("FAIL b2b_a1: got ov=%b idx=%0d last=%b seq=%0d want 1 2 1 1",
               m_ov, m_idx, m_ol, m_seq);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (!(m_ov === 1'b0 && m_ir === 1'b1))
      $display("FAIL b2b_gap: got ov=%b ir=%b want 0 1", m_ov, m_ir);
    else n_pass++;
    @(negedge clk);
    m_iv = 1'b0;
    n_total++;
    if (!(m_ov === 1'b1 && m_idx === 8'd9 && m_ol === 1'b1 && m_seq === 9'd0))
      $display("FAIL b2b_b: got ov=%b idx=%0d last=%b seq=%0d want 1 9 1 0",
               m_ov, m_idx, m_ol, m_seq);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (!(m_ov === 1'b0 && m_ir === 1'b1))
      $display("FAIL b2b_end: got ov=%b ir=%b want 0 1", m_ov, m_ir);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    m_or = 1'b1;
    m_vec = '1;
    m_iv = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      m_iv = 1'b0;
      n_total++;
      if (!(m_ov === 1'b1 && m_idx === 8'(255 - k) &&
            m_seq === 9'(k) && m_ol === 1'b0))
        $display("FAIL all1_emit%0d: got ov=%b idx=%0d seq=%0d last=%b want 1 %0d %0d 0",
                 k, m_ov, m_idx, m_seq, m_ol, 255 - k, k);
      else n_pass++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (!(m_ov === 1'b0 && m_ir === 1'b1 && m_seq === 9'd0))
      $display("FAIL mid_rst: got ov=%b ir=%b seq=%0d want 0 1 0", m_ov, m_ir, m_seq);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (m_ov !== 1'b0)
      $display("FAIL mid_rst_quiet: got ov=%b want 0", m_ov);
    else n_pass++;
    m_vec = 256'h1;
    m_iv = 1'b1;
    @(negedge clk);
    m_iv = 1'b0;
    n_total++;
    if (!(m_ov === 1'b1 && m_idx === 8'd0 && m_ol === 1'b1 && m_seq === 9'd0))
      $display("FAIL post_rst: got ov=%b idx=%0d last=%b seq=%0d want 1 0 1 0",
               m_ov, m_idx, m_ol, m_seq);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (!(m_ov === 1'b0 && m_ir === 1'b1))
      $display("FAIL post_rst_idle: got ov=%b ir=%b want 0 1", m_ov, m_ir);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_msb_order();
    test_lsb_order();
    test_walking_one();
    test_zero_vec();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
